capture_ctl: RTL and testbench

Sample-capture controller feeding the write path in the `core_clk` domain. It decimates the raw probe bus by a programmable divider and applies a pre/post-trigger depth policy. It emits a `capture_valid`/`capture_data` stream plus a level `capture_done` for the downstream write FIFO stage. Write-FIFO backpressure is reported as a sticky overflow flag rather than stalling sampling.

---
 rtl/capture_ctl_if.sv | 27 ++
 rtl/capture_ctl.sv | 175 +++++++++++++++++
 tb/tb_capture_ctl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/capture_ctl_if.sv
// Capture stream bundle between capture_ctl and the write FIFO stage.
// Master drives samples and status; slave reports FIFO full.
interface capture_ctl_if #(
    parameter int DW = 16
);
    logic          capture_valid;
    logic [DW-1:0] capture_data;
    logic          capture_done;
    logic          capture_ovf;
    logic          wfifo_full;

    modport master (
        output capture_valid,
        output capture_data,
        output capture_done,
        output capture_ovf,
        input  wfifo_full
    );

    modport slave (
        input  capture_valid,
        input  capture_data,
        input  capture_done,
        input  capture_ovf,
        output wfifo_full
    );
endinterface

// File: rtl/capture_ctl.sv
// Sample-capture controller: decimates the probe bus and applies a
// pre/post-trigger depth policy, streaming samples to the write FIFO.
module capture_ctl #(
    parameter int DW = 16,
    parameter int CW = 32
) (
    input  logic          core_clk,
    input  logic          core_rst,
    input  logic          sample_en,
    input  logic [23:0]   sample_div,
    input  logic [CW-1:0] pre_depth,
    input  logic [CW-1:0] post_depth,
    input  logic          trig_hit,
    input  logic [DW-1:0] probe_data,
    capture_ctl_if.master cap,
    output logic [CW-1:0] trig_pos,
    output logic [CW-1:0] sample_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        POST,
        DONE
    } state_t;

    localparam logic [CW-1:0] ONE = CW'(1);

    state_t        state_q, state_d;
    logic          en_q;
    logic [DW-1:0] pd_q;
    logic [23:0]   div_s_q, div_s_d;
    logic [CW-1:0] pre_s_q, pre_s_d;
    logic [CW-1:0] post_s_q, post_s_d;
    logic [23:0]   div_cnt_q, div_cnt_d;
    logic [CW-1:0] pre_cnt_q, pre_cnt_d;
    logic [CW-1:0] post_cnt_q, post_cnt_d;
    logic [CW-1:0] trig_pos_q, trig_pos_d;
    logic [CW-1:0] sample_cnt_q, sample_cnt_d;
    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;
    logic          done_q, done_d;
    logic          ovf_q, ovf_d;

    logic          run;
    logic          tick;
    logic [CW-1:0] post_lim;

    always_comb begin
        state_d      = state_q;
        div_s_d      = div_s_q;
        pre_s_d      = pre_s_q;
        post_s_d     = post_s_q;
        pre_cnt_d    = pre_cnt_q;
        post_cnt_d   = post_cnt_q;
        trig_pos_d   = trig_pos_q;
        sample_cnt_d = sample_cnt_q;
        data_d       = data_q;
        done_d       = done_q;
        ovf_d        = ovf_q;

        run      = (state_q == PRE) || (state_q == POST);
        tick     = run && (div_cnt_q == div_s_q);
        post_lim = (post_s_q == '0) ? ONE : post_s_q;

        if (!run) begin
            div_cnt_d = '0;
        end else if (tick) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + 24'd1;
        end

        // A tick always emits, even while full or on the abort cycle
        valid_d = tick;
        if (tick) begin
            data_d       = pd_q;
            sample_cnt_d = sample_cnt_q + ONE;
            if (cap.wfifo_full) begin
                ovf_d = 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (sample_en && !en_q) begin
                    state_d      = PRE;
                    div_s_d      = sample_div;
                    pre_s_d      = pre_depth;
                    post_s_d     = post_depth;
                    pre_cnt_d    = '0;
                    post_cnt_d   = '0;
                    trig_pos_d   = '0;
                    sample_cnt_d = '0;
                    ovf_d        = 1'b0;
                    done_d       = 1'b0;
                end
            end
            PRE: begin
                if (!sample_en) begin
                    state_d = DONE;
                end else if (tick) begin
                    if (trig_hit && (pre_cnt_q >= pre_s_q)) begin
                        trig_pos_d = pre_cnt_q;
                        post_cnt_d = ONE;
                        state_d    = (post_lim == ONE) ? DONE : POST;
                    end else begin
                        pre_cnt_d = pre_cnt_q + ONE;
                    end
                end
            end
            POST: begin
                if (!sample_en) begin
                    state_d = DONE;
                end else if (tick) begin
                    post_cnt_d = post_cnt_q + ONE;
                    if ((post_cnt_q + ONE) == post_lim) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                done_d = 1'b1;
                if (!sample_en) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            state_q      <= IDLE;
            en_q         <= 1'b0;
            pd_q         <= '0;
            div_s_q      <= '0;
            pre_s_q      <= '0;
            post_s_q     <= '0;
            div_cnt_q    <= '0;
            pre_cnt_q    <= '0;
            post_cnt_q   <= '0;
            trig_pos_q   <= '0;
            sample_cnt_q <= '0;
            valid_q      <= 1'b0;
            data_q       <= '0;
            done_q       <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            en_q         <= sample_en;
            pd_q         <= probe_data;
            div_s_q      <= div_s_d;
            pre_s_q      <= pre_s_d;
            post_s_q     <= post_s_d;
            div_cnt_q    <= div_cnt_d;
            pre_cnt_q    <= pre_cnt_d;
            post_cnt_q   <= post_cnt_d;
            trig_pos_q   <= trig_pos_d;
            sample_cnt_q <= sample_cnt_d;
            valid_q      <= valid_d;
            data_q       <= data_d;
            done_q       <= done_d;
            ovf_q        <= ovf_d;
        end
    end

    assign cap.capture_valid = valid_q;
    assign cap.capture_data  = data_q;
    assign cap.capture_done  = done_q;
    assign cap.capture_ovf   = ovf_q;
    assign trig_pos          = trig_pos_q;
    assign sample_cnt        = sample_cnt_q;

endmodule

// File: tb/tb_capture_ctl.sv
// Scoreboard bench for capture_ctl: expected samples are queued at arm
// time with their emit cycle and data, then matched on each valid.
module tb_capture_ctl;

    logic        clk = 1'b0;
    logic        core_rst;
    logic        sample_en;
    logic [23:0] sample_div;
    logic [31:0] pre_depth;
    logic [31:0] post_depth;
    logic        trig_hit;
    logic [15:0] probe_data;
    logic [31:0] trig_pos;
    logic [31:0] sample_cnt;

    logic [31:0] cyc = '0;
    logic [31:0] t0 = '0;
    logic        trig_c = 1'b0;
    logic        trig_e = 1'b0;
    logic        bp_en = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] c;
        logic [15:0] d;
    } sb_t;

    sb_t sb[$];
    sb_t mon_e;

    capture_ctl_if #(.DW(16)) cif ();

    capture_ctl #(
        .DW(16),
        .CW(32)
    ) dut (
        .core_clk  (clk),
        .core_rst  (core_rst),
        .sample_en (sample_en),
        .sample_div(sample_div),
        .pre_depth (pre_depth),
        .post_depth(post_depth),
        .trig_hit  (trig_hit),
        .probe_data(probe_data),
        .cap       (cif.master),
        .trig_pos  (trig_pos),
        .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 32'd1;

    assign probe_data = cyc[15:0];
    assign trig_hit = trig_c |
        (trig_e && ((cyc == t0 + 32'd3) || (cyc == t0 + 32'd10)));
    assign cif.wfifo_full = bp_en && (cyc == t0 + 32'd6);

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cif.capture_valid) begin
            if (sb.size() == 0) begin
                chk("extra_valid", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("v_cyc", cyc, mon_e.c);
                chk("v_data", {16'd0, cif.capture_data}, {16'd0, mon_e.d});
            end
        end
    end

    task automatic push_exp(input int div, input int n);
        logic [31:0] vc;
        for (int i = 0; i < n; i++) begin
            vc = t0 + 32'd2 + 32'(div) + 32'(i * (div + 1));
            sb.push_back('{vc, 16'(vc - 32'd2)});
        end
    endtask

    task automatic arm(input int div, input int pre, input int post);
        @(negedge clk);
        sample_en  = 1'b0;
        sample_div = 24'(div);
        pre_depth  = 32'(pre);
        post_depth = 32'(post);
        @(negedge clk);
        t0 = cyc;
        sample_en = 1'b1;
    endtask

    task automatic run(input int div, input int pre, input int post,
                       input int n, input int tp,
                       input bit tc, input bit te, input bit bp);
        int k;
        trig_c = tc;
        arm(div, pre, post);
        trig_e = te;
        bp_en  = bp;
        push_exp(div, n);
        @(negedge clk);
        chk("arm_done_clr", {31'd0, cif.capture_done}, 32'd0);
        chk("arm_cnt_clr", sample_cnt, 32'd0);
        chk("arm_ovf_clr", {31'd0, cif.capture_ovf}, 32'd0);
        // shadowed settings must ignore mid-run changes
        sample_div = 24'(div + 5);
        post_depth = 32'(post + 3);
        k = 0;
        while (!cif.capture_done && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (k >= 500) chk("done_timeout", 32'd0, 32'd1);
        chk("done_cyc", cyc,
            t0 + 32'd3 + 32'(div) + 32'((n - 1) * (div + 1)));
        chk("trig_pos", trig_pos, 32'(tp));
        chk("sample_cnt", sample_cnt, 32'(n));
        chk("ovf", {31'd0, cif.capture_ovf}, {31'd0, bp});
        chk("sb_empty", 32'(sb.size()), 32'd0);
        sample_en = 1'b0;
        trig_c = 1'b0;
        trig_e = 1'b0;
        bp_en  = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        core_rst   = 1'b1;
        sample_en  = 1'b0;
        sample_div = '0;
        pre_depth  = '0;
        post_depth = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid", {31'd0, cif.capture_valid}, 32'd0);
        chk("rst_done", {31'd0, cif.capture_done}, 32'd0);
        chk("rst_ovf", {31'd0, cif.capture_ovf}, 32'd0);
        chk("rst_data", {16'd0, cif.capture_data}, 32'd0);
        chk("rst_tpos", trig_pos, 32'd0);
        chk("rst_cnt", sample_cnt, 32'd0);
        core_rst = 1'b0;

        run(0, 4, 8, 12, 4, 1'b1, 1'b0, 1'b0);
        run(3, 0, 5, 5, 0, 1'b1, 1'b0, 1'b0);
        run(0, 6, 3, 12, 9, 1'b0, 1'b1, 1'b0);

        // abort in PRE after three samples
        trig_c = 1'b0;
        arm(3, 10, 5);
        push_exp(3, 3);
        while (cyc < t0 + 32'd13) @(negedge clk);
        sample_en = 1'b0;
        a = cyc;
        @(negedge clk);
        chk("abort_early", {31'd0, cif.capture_done}, 32'd0);
        @(negedge clk);
        chk("abort_done", {31'd0, cif.capture_done}, 32'd1);
        chk("abort_cyc", cyc, a + 32'd2);
        chk("abort_cnt", sample_cnt, 32'd3);
        repeat (6) @(negedge clk);
        chk("abort_sb", 32'(sb.size()), 32'd0);
        chk("abort_hold", {31'd0, cif.capture_done}, 32'd1);

        run(1, 0, 5, 5, 0, 1'b1, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        chk("ovf_hold", {31'd0, cif.capture_ovf}, 32'd1);

        // reset in the middle of POST
        trig_c = 1'b1;
        arm(0, 0, 20);
        push_exp(0, 20);
        while (cyc < t0 + 32'd8) @(negedge clk);
        core_rst  = 1'b1;
        sample_en = 1'b0;
        @(negedge clk);
        chk("mrst_valid", {31'd0, cif.capture_valid}, 32'd0);
        chk("mrst_done", {31'd0, cif.capture_done}, 32'd0);
        chk("mrst_data", {16'd0, cif.capture_data}, 32'd0);
        chk("mrst_cnt", sample_cnt, 32'd0);
        chk("mrst_state", 32'(dut.state_q), 32'd0);
        chk("mrst_sb", 32'(sb.size()), 32'd13);
        sb.delete();
        core_rst = 1'b0;
        trig_c = 1'b0;
        repeat (3) @(negedge clk);
        chk("mrst_quiet", {31'd0, cif.capture_done}, 32'd0);

        run(0, 2, 3, 5, 2, 1'b1, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
